// File: rtl/hex_scan_driver.sv
// Time-multiplexed scan driver for an NDIG-digit hex display.
// One digit is selected per slot of DIV clocks. The current nibble goes to the
// downstream seven-segment decoder, and active-low digit enables are produced
// alongside it. Display values are double-buffered: a loaded value is held in
// a pending register and only becomes visible at a frame boundary, so a frame
// never mixes digits from two different values.
module hex_scan_driver #(
    parameter int NDIG     = 4,
    parameter int DIV      = 50000,
    parameter int BLANK_LZ = 1,
    localparam int IW      = $clog2(NDIG),
    localparam int CW      = $clog2(DIV)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] value,
    input  logic              load,
    output logic [3:0]        bin,
    output logic [NDIG-1:0]   an,
    output logic              blank,
    output logic [IW-1:0]     idx
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0]     cnt_reg;
    logic [IW-1:0]     idx_reg;
    logic [4*NDIG-1:0] shadow_reg;
    logic [4*NDIG-1:0] pend_reg;
    logic              pflag_reg;

    logic              cnt_wrap;
    logic              frame_end;
    logic              lz_blank;
    logic              lit;

    // nibble view of the displayed value, and "some nibble at or above k is nonzero"
    logic [3:0]        nibble  [NDIG];
    logic [NDIG-1:0]   nz_from;

    assign cnt_wrap  = (cnt_reg == CNT_LAST);
    assign frame_end = cnt_wrap && (idx_reg == IDX_LAST);

    // Prescaler and digit index: idx advances each time the slot counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            idx_reg <= '0;
        end else begin
            cnt_reg <= cnt_wrap ? '0 : cnt_reg + CW'(1);
            if (cnt_wrap) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
            end
        end
    end

    // Double buffer: LOAD fills the pending register; the frame boundary
    // publishes it. A LOAD landing on the boundary edge bypasses the pending
    // stage so the new value shows from the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg <= '0;
            pend_reg   <= '0;
            pflag_reg  <= 1'b0;
        end else if (load && frame_end) begin
            shadow_reg <= value;
            pend_reg   <= value;
            pflag_reg  <= 1'b0;
        end else if (load) begin
            pend_reg   <= value;
            pflag_reg  <= 1'b1;
        end else if (frame_end && pflag_reg) begin
            shadow_reg <= pend_reg;
            pflag_reg  <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign nibble[gi]  = shadow_reg[4*gi +: 4];
            assign nz_from[gi] = |shadow_reg[4*NDIG-1:4*gi];
            // Enable is low only for the selected digit while it is lit.
            assign an[gi]      = ~(lit && (idx_reg == IW'(gi)));
        end
    endgenerate

    // Digit selection and lit/blank decision from the registered scan state.
    always_comb begin
        bin      = nibble[idx_reg];
        lz_blank = (BLANK_LZ != 0) && (idx_reg != '0) && !nz_from[idx_reg];
        // cnt==0 is the dead cycle that stops ghosting across digit changes.
        lit      = (cnt_reg != '0) && !lz_blank;
    end

    assign blank = &an;
    assign idx   = idx_reg;

endmodule
